// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// Sequences one multiply between the control unit and an external multiplier,
// captures the 64-bit product and owns the architectural HI/LO registers.
// It also serves MFHI/MFLO reads and MTHI/MTLO writes, and stalls control
// while a product is pending.
//
// Optional feature macro: HILO_MADD_EN
//   When defined, adds the MultAcc input. A multiply requested with
//   MultAcc=1 accumulates into {Hi,Lo} through an extra ACCUM state instead
//   of overwriting them.
//
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   MultReq    in   one-cycle multiply request from control
//   OpA/OpB    in   operands, sampled when MultReq is accepted
//   MultAcc    in   (HILO_MADD_EN only) accumulate request, sampled with MultReq
//   MultA/B    out  registered operands to the multiplier
//   CtoM       out  one-cycle start pulse to the multiplier
//   MtoC       in   done pulse from the multiplier
//   MultHigh   in   product high word, valid with MtoC
//   MultLow    in   product low word, valid with MtoC
//   HiWrite    in   MTHI write enable
//   LoWrite    in   MTLO write enable
//   WriteData  in   MTHI/MTLO data
//   ReadHiLo   in   control is executing MFHI/MFLO this cycle
//   Hi/Lo      out  architectural HI/LO
//   Busy       out  multiply in flight
//   Stall      out  combinational stall to control
//   Timeout    out  sticky flag: a multiply was abandoned
// -----------------------------------------------------------------------------
module hilo_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MultReq,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
`ifdef HILO_MADD_EN
  input  logic        MultAcc,
`endif
  output logic [31:0] MultA,
  output logic [31:0] MultB,
  output logic        CtoM,
  input  logic        MtoC,
  input  logic [31:0] MultHigh,
  input  logic [31:0] MultLow,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WriteData,
  input  logic        ReadHiLo,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Stall,
  output logic        Timeout
);

`ifdef HILO_MADD_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ACCUM} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_e;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      mult_a_q, mult_a_d;
  logic [31:0]      mult_b_q, mult_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`ifdef HILO_MADD_EN
  logic             acc_q, acc_d;
  logic [63:0]      prod_q, prod_d;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mult_a_d  = mult_a_q;
    mult_b_d  = mult_b_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`ifdef HILO_MADD_EN
    acc_d     = acc_q;
    prod_d    = prod_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // A multiply request takes priority over MTHI/MTLO in the same cycle.
        if (MultReq) begin
          mult_a_d = OpA;
          mult_b_d = OpB;
`ifdef HILO_MADD_EN
          acc_d    = MultAcc;
`endif
          state_d  = S_START;
        end else begin
          if (HiWrite) hi_d = WriteData;
          if (LoWrite) lo_d = WriteData;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Done wins over the timeout limit when both land in the same cycle.
        if (MtoC) begin
`ifdef HILO_MADD_EN
          if (acc_q) begin
            prod_d  = {MultHigh, MultLow};
            state_d = S_ACCUM;
          end else begin
            hi_d    = MultHigh;
            lo_d    = MultLow;
            state_d = S_IDLE;
          end
`else
          hi_d    = MultHigh;
          lo_d    = MultLow;
          state_d = S_IDLE;
`endif
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef HILO_MADD_EN
      S_ACCUM: begin
        // 64-bit sum; the carry out of bit 63 is dropped.
        {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
        state_d      = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before this edge, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mult_a_q  <= '0;
      mult_b_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef HILO_MADD_EN
      acc_q     <= 1'b0;
      prod_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mult_a_q  <= mult_a_d;
      mult_b_q  <= mult_b_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`ifdef HILO_MADD_EN
      acc_q     <= acc_d;
      prod_q    <= prod_d;
`endif
    end
  end

  // CtoM is a pure decode of the registered state, so it is glitch-free and
  // high for exactly the single START cycle.
  assign CtoM    = (state_q == S_START);
  assign Busy    = (state_q != S_IDLE);
  assign Stall   = Busy & (MultReq | HiWrite | LoWrite | ReadHiLo);
  assign MultA   = mult_a_q;
  assign MultB   = mult_b_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//
// Directed bench for hilo_unit: table-driven MTHI/MTLO and multiply vectors,
// plus hand-written sequences for stall, timeout, reset-abort and (when
// HILO_MADD_EN is defined) multiply-accumulate.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        MultReq;
  logic [31:0] OpA, OpB;
`ifdef HILO_MADD_EN
  logic        MultAcc;
`endif
  logic [31:0] MultA, MultB;
  logic        CtoM;
  logic        MtoC;
  logic [31:0] MultHigh, MultLow;
  logic        HiWrite, LoWrite;
  logic [31:0] WriteData;
  logic        ReadHiLo;
  logic [31:0] Hi, Lo;
  logic        Busy, Stall, Timeout;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_unit #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .MultReq  (MultReq),
    .OpA      (OpA),
    .OpB      (OpB),
`ifdef HILO_MADD_EN
    .MultAcc  (MultAcc),
`endif
    .MultA    (MultA),
    .MultB    (MultB),
    .CtoM     (CtoM),
    .MtoC     (MtoC),
    .MultHigh (MultHigh),
    .MultLow  (MultLow),
    .HiWrite  (HiWrite),
    .LoWrite  (LoWrite),
    .WriteData(WriteData),
    .ReadHiLo (ReadHiLo),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Stall    (Stall),
    .Timeout  (Timeout)
  );

  always #5 Clock = ~Clock;

  // Hard stop in case a sequence is ever miscounted.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] data;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } wr_vec_t;

  typedef struct {
    logic [31:0] opa;
    logic [31:0] opb;
    int          k;       // WAIT cycles with MtoC low before the done pulse
    logic [31:0] high;
    logic [31:0] low;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } mul_vec_t;

  // One complete multiply: MtoC is also pulsed during START with junk data,
  // which must be ignored.
  task automatic do_mult(input logic [31:0] opa, input logic [31:0] opb, input int k,
                         input logic [31:0] high, input logic [31:0] low,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_to);
    int ctom_cnt;
    OpA = opa; OpB = opb; MultReq = 1'b1;
    #1 check("req_no_stall", Stall, 0);
    tick();
    MultReq = 1'b0; OpA = 32'hFFFF_0000; OpB = 32'h0000_FFFF;
    check("start_ctom", CtoM, 1);
    check("start_busy", Busy, 1);
    MtoC = 1'b1; MultHigh = 32'hBAD0_BAD0; MultLow = 32'hBAD1_BAD1;
    tick();
    MtoC = 1'b0;
    check("wait_busy", Busy, 1);
    check("wait_multa", MultA, opa);
    check("wait_multb", MultB, opb);
    ctom_cnt = 0;
    for (int i = 0; i < k; i++) begin
      if (CtoM) ctom_cnt++;
      tick();
    end
    if (CtoM) ctom_cnt++;
    check("ctom_single_pulse", ctom_cnt, 0);
    check("busy_before_done", Busy, 1);
    MtoC = 1'b1; MultHigh = high; MultLow = low;
    tick();
    MtoC = 1'b0;
    check("done_busy", Busy, 0);
    check("done_hi", Hi, exp_hi);
    check("done_lo", Lo, exp_lo);
    check("done_timeout", Timeout, exp_to);
  endtask

  wr_vec_t  wr_tbl[5];
  mul_vec_t mul_tbl[3];

  initial begin
    // Expected values worked out by hand from the register semantics.
    wr_tbl[0] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    wr_tbl[1] = '{1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
    wr_tbl[2] = '{1'b0, 1'b1, 32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D};
    wr_tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hCAFE_F00D};
    wr_tbl[4] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    // 7*6 = 42; (2^32-1)^2 = 0xFFFFFFFE_00000001; 2^16*2^16 = 2^32.
    mul_tbl[0] = '{32'd7, 32'd6, 32, 32'h0, 32'd42, 32'h0, 32'd42};
    mul_tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h1,
                   32'hFFFF_FFFE, 32'h1};
    mul_tbl[2] = '{32'h1_0000, 32'h1_0000, 39, 32'h1, 32'h0, 32'h1, 32'h0};

    Reset = 1'b1; MultReq = 1'b0; OpA = '0; OpB = '0; MtoC = 1'b0;
    MultHigh = '0; MultLow = '0; HiWrite = 1'b0; LoWrite = 1'b0;
    WriteData = '0; ReadHiLo = 1'b0;
`ifdef HILO_MADD_EN
    MultAcc = 1'b0;
`endif
    tick(); tick();
    Reset = 1'b0;

    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    check("rst_busy", Busy, 0);
    check("rst_ctom", CtoM, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_multa", MultA, 0);

    // MTHI/MTLO in IDLE.
    for (int i = 0; i < 5; i++) begin
      HiWrite = wr_tbl[i].hi_we; LoWrite = wr_tbl[i].lo_we; WriteData = wr_tbl[i].data;
      #1 check("wr_stall", Stall, 0);
      tick();
      check("wr_hi", Hi, wr_tbl[i].exp_hi);
      check("wr_lo", Lo, wr_tbl[i].exp_lo);
    end
    HiWrite = 1'b0; LoWrite = 1'b0;

    // Multiplies, including the done-at-the-timeout-limit boundary (k=39).
    for (int i = 0; i < 3; i++)
      do_mult(mul_tbl[i].opa, mul_tbl[i].opb, mul_tbl[i].k, mul_tbl[i].high,
              mul_tbl[i].low, mul_tbl[i].exp_hi, mul_tbl[i].exp_lo, 1'b0);

    // Stall: MFHI + MTHI + MultReq presented mid-WAIT.
    OpA = 32'd3; OpB = 32'd5; MultReq = 1'b1;
    tick();
    MultReq = 1'b0;
    tick();
    tick();
    ReadHiLo = 1'b1; HiWrite = 1'b1; WriteData = 32'h5555_5555;
    MultReq = 1'b1; OpA = 32'h0000_FFFF;
    #1 check("stall_mid_wait", Stall, 1);
    tick(); tick();
    check("stall_multa_held", MultA, 32'd3);
    check("stall_hi_held", Hi, 32'h1);
    MultReq = 1'b0;
    #1 check("stall_still", Stall, 1);
    MtoC = 1'b1; MultHigh = 32'h0; MultLow = 32'd15;
    tick();
    MtoC = 1'b0;
    check("stall_released", Stall, 0);
    check("stall_hi_is_product", Hi, 32'h0);
    check("stall_lo_is_product", Lo, 32'd15);
    tick();
    check("stall_hi_rewritten", Hi, 32'h5555_5555);
    check("stall_lo_kept", Lo, 32'd15);
    ReadHiLo = 1'b0; HiWrite = 1'b0;

    // Timeout: no done pulse for 40 WAIT cycles.
    HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'h1111_2222;
    tick();
    LoWrite = 1'b0; HiWrite = 1'b0;
    OpA = 32'd9; OpB = 32'd9; MultReq = 1'b1;
    tick();
    MultReq = 1'b0;
    tick();
    for (int i = 0; i < 39; i++) tick();
    check("to_busy_at_39", Busy, 1);
    check("to_flag_at_39", Timeout, 0);
    tick();
    check("to_busy_after", Busy, 0);
    check("to_flag_after", Timeout, 1);
    check("to_hi_kept", Hi, 32'h1111_2222);
    check("to_lo_kept", Lo, 32'h1111_2222);
    MtoC = 1'b1; MultHigh = 32'h9999_9999; MultLow = 32'h8888_8888;
    tick();
    MtoC = 1'b0;
    check("late_mtoc_hi", Hi, 32'h1111_2222);
    check("late_mtoc_lo", Lo, 32'h1111_2222);
    check("late_mtoc_busy", Busy, 0);

    // Timeout stays set across a later successful multiply.
    do_mult(32'd2, 32'd3, 5, 32'h0, 32'd6, 32'h0, 32'd6, 1'b1);

`ifdef HILO_MADD_EN
    // {0,FFFFFFFF} + {0,1} = {1,0}.
    HiWrite = 1'b1; LoWrite = 1'b0; WriteData = 32'h0;
    tick();
    HiWrite = 1'b0; LoWrite = 1'b1; WriteData = 32'hFFFF_FFFF;
    tick();
    LoWrite = 1'b0;
    OpA = 32'd1; OpB = 32'd1; MultAcc = 1'b1; MultReq = 1'b1;
    tick();
    MultReq = 1'b0; MultAcc = 1'b0;
    tick();
    MtoC = 1'b1; MultHigh = 32'h0; MultLow = 32'h1;
    tick();
    MtoC = 1'b0;
    check("madd_accum_busy", Busy, 1);
    check("madd_lo_pending", Lo, 32'hFFFF_FFFF);
    tick();
    check("madd_hi", Hi, 32'h1);
    check("madd_lo", Lo, 32'h0);
    check("madd_busy", Busy, 0);
`endif

    // Reset during WAIT aborts; a later done pulse is ignored.
    OpA = 32'd4; OpB = 32'd4; MultReq = 1'b1;
    tick();
    MultReq = 1'b0;
    tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_wait_busy", Busy, 0);
    check("rst_wait_ctom", CtoM, 0);
    check("rst_wait_timeout", Timeout, 0);
    check("rst_wait_multa", MultA, 0);
    MtoC = 1'b1; MultHigh = 32'h0; MultLow = 32'h1234;
    tick();
    MtoC = 1'b0;
    check("rst_wait_hi", Hi, 0);
    check("rst_wait_lo", Lo, 0);
    check("rst_wait_idle", Busy, 0);
    check("rst_wait_ctom2", CtoM, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
